// File: rtl/sm_add_seq_ctrl.sv
// Operand-entry sequencer for the sign-magnitude adder demo: conditions the
// step/clear buttons, registers A/B for the external adder and latches the result.
module sm_add_seq_ctrl #(
    parameter int N = 4
) (
    input  logic         clk_amisha,
    input  logic         reset_amisha,
    input  logic         btn_next_amisha,
    input  logic         btn_clr_amisha,
    input  logic [N-1:0] sw_amisha,
    input  logic [N-1:0] sum_amisha,
    output logic [N-1:0] a_amisha,
    output logic [N-1:0] b_amisha,
    output logic [N-1:0] mout_amisha,
    output logic         ovf_amisha,
    output logic         done_amisha,
    output logic [2:0]   state_amisha
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GET_A = 3'd1,
        GET_B = 3'd2,
        ADD   = 3'd3,
        SHOW  = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic [1:0] btn_raw;
    logic [1:0] sync1_q, sync2_q, hist_q, pulse_q;
    logic       next_pulse, clr_pulse;

    logic [N-1:0] a_q, a_d, b_q, b_d, mout_q, mout_d, res_q, res_d;
    logic         ovf_q, ovf_d, done_q, done_d;
    logic [N-1:0] mag_sum;
    logic         ovf_calc;
    logic [N-1:0] sum_fixed;

    assign btn_raw = {btn_clr_amisha, btn_next_amisha};

    // Flops reset high so a button held through reset release reads as "already seen".
    always_ff @(posedge clk_amisha or negedge reset_amisha) begin
        if (!reset_amisha) begin
            sync1_q <= '1;
            sync2_q <= '1;
            hist_q  <= '1;
            pulse_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            pulse_q <= sync2_q & ~hist_q;
        end
    end

    assign next_pulse = pulse_q[0];
    assign clr_pulse  = pulse_q[1];

    // Magnitudes summed at full N bits so the carry into the sign position is visible.
    assign mag_sum   = {1'b0, a_q[N-2:0]} + {1'b0, b_q[N-2:0]};
    assign ovf_calc  = (a_q[N-1] == b_q[N-1]) & mag_sum[N-1];
    assign sum_fixed = {sum_amisha[N-1] & (|sum_amisha[N-2:0]), sum_amisha[N-2:0]};

    always_ff @(posedge clk_amisha or negedge reset_amisha) begin
        if (!reset_amisha) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr_pulse) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (next_pulse) state_d = GET_A;
                GET_A:   if (next_pulse) state_d = GET_B;
                GET_B:   if (next_pulse) state_d = ADD;
                ADD:     state_d = SHOW;
                SHOW:    if (next_pulse) state_d = GET_A;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        mout_d = mout_q;
        res_d  = res_q;
        ovf_d  = 1'b0;
        done_d = 1'b0;
        if (clr_pulse) begin
            a_d    = '0;
            b_d    = '0;
            mout_d = '0;
            res_d  = '0;
        end else begin
            case (state_q)
                GET_A: begin
                    mout_d = sw_amisha;
                    if (next_pulse) a_d = sw_amisha;
                end
                GET_B: begin
                    mout_d = sw_amisha;
                    if (next_pulse) b_d = sw_amisha;
                end
                ADD: begin
                    res_d  = sum_fixed;
                    mout_d = sum_fixed;
                    ovf_d  = ovf_calc;
                    done_d = 1'b1;
                end
                SHOW: begin
                    mout_d = res_q;
                    ovf_d  = ovf_q & ~next_pulse;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_amisha or negedge reset_amisha) begin
        if (!reset_amisha) begin
            a_q    <= '0;
            b_q    <= '0;
            mout_q <= '0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            mout_q <= mout_d;
            res_q  <= res_d;
            ovf_q  <= ovf_d;
            done_q <= done_d;
        end
    end

    assign a_amisha     = a_q;
    assign b_amisha     = b_q;
    assign mout_amisha  = mout_q;
    assign ovf_amisha   = ovf_q;
    assign done_amisha  = done_q;
    assign state_amisha = state_q;

endmodule

// File: tb/tb_sm_add_seq_ctrl.sv
// Directed and randomized check of the operand-entry sequencer against a
// value-level model of sign-magnitude addition.
module tb_sm_add_seq_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         btn_next = 1'b0;
    logic         btn_clr = 1'b0;
    logic [N-1:0] sw = '0;
    logic [N-1:0] sum;
    logic [N-1:0] a_o, b_o, mout_o;
    logic         ovf_o, done_o;
    logic [2:0]   state_o;

    int passed = 0;
    int total  = 0;
    int done_cnt = 0;
    int seq_code = 0;
    logic [2:0] last_state = 3'd0;

    always #5 clk = ~clk;

    sm_add_seq_ctrl #(.N(N)) dut (
        .clk_amisha      (clk),
        .reset_amisha    (rst_n),
        .btn_next_amisha (btn_next),
        .btn_clr_amisha  (btn_clr),
        .sw_amisha       (sw),
        .sum_amisha      (sum),
        .a_amisha        (a_o),
        .b_amisha        (b_o),
        .mout_amisha     (mout_o),
        .ovf_amisha      (ovf_o),
        .done_amisha     (done_o),
        .state_amisha    (state_o)
    );

    // External combinational adder; on equal magnitudes it returns B's sign (may yield -0).
    function automatic logic [3:0] ext_add(input logic [3:0] a, input logic [3:0] b);
        logic [2:0] m;
        if (a[3] == b[3]) begin
            m = a[2:0] + b[2:0];
            return {a[3], m};
        end else if (a[2:0] > b[2:0]) begin
            m = a[2:0] - b[2:0];
            return {a[3], m};
        end else begin
            m = b[2:0] - a[2:0];
            return {b[3], m};
        end
    endfunction

    assign sum = ext_add(a_o, b_o);

    function automatic logic exp_ovf(input logic [3:0] a, input logic [3:0] b);
        int ma = int'(a[2:0]);
        int mb = int'(b[2:0]);
        return (a[3] == b[3]) && (ma + mb > 7);
    endfunction

    function automatic logic [3:0] exp_result(input logic [3:0] a, input logic [3:0] b);
        int ma = int'(a[2:0]);
        int mb = int'(b[2:0]);
        int va, vb, s, mag;
        logic sg;
        if (exp_ovf(a, b)) begin
            sg  = a[3];
            mag = (ma + mb) % 8;
        end else begin
            va  = a[3] ? -ma : ma;
            vb  = b[3] ? -mb : mb;
            s   = va + vb;
            sg  = (s < 0);
            mag = (s < 0) ? -s : s;
        end
        if (mag == 0) sg = 1'b0;
        return {sg, mag[2:0]};
    endfunction

    // Records state visits (octal digits) and done-high cycles, sampled just after each edge.
    always @(posedge clk) begin
        #1;
        if (done_o === 1'b1) done_cnt = done_cnt + 1;
        if (state_o !== last_state) begin
            seq_code   = seq_code * 8 + int'(state_o);
            last_state = state_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic press_next();
        @(negedge clk) btn_next = 1'b1;
        repeat (3) @(negedge clk);
        btn_next = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic press_clr();
        @(negedge clk) btn_clr = 1'b1;
        repeat (3) @(negedge clk);
        btn_clr = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Three presses from IDLE or SHOW: enter A, enter B, add and show.
    task automatic do_op(input string tag, input logic [3:0] av, input logic [3:0] bv);
        int d0;
        logic [3:0] er;
        logic eo;
        er = exp_result(av, bv);
        eo = exp_ovf(av, bv);
        seq_code = 0;
        sw = av;
        press_next();
        chk({tag, "_stA"}, 32'(state_o), 32'd1);
        chk({tag, "_ovfA"}, 32'(ovf_o), 32'd0);
        chk({tag, "_moutA"}, 32'(mout_o), 32'(av));
        press_next();
        chk({tag, "_stB"}, 32'(state_o), 32'd2);
        chk({tag, "_a"}, 32'(a_o), 32'(av));
        sw = bv;
        d0 = done_cnt;
        press_next();
        chk({tag, "_b"}, 32'(b_o), 32'(bv));
        chk({tag, "_st"}, 32'(state_o), 32'd4);
        chk({tag, "_mout"}, 32'(mout_o), 32'(er));
        chk({tag, "_ovf"}, 32'(ovf_o), 32'(eo));
        chk({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_seq"}, 32'(seq_code), 32'(((1 * 8 + 2) * 8 + 3) * 8 + 4));
        $display("op %s: a=%b b=%b mout=%b ovf=%b", tag, a_o, b_o, mout_o, ovf_o);
    endtask

    initial begin
        logic [3:0] ra, rb;

        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_a", 32'(a_o), 32'd0);
        chk("rst_b", 32'(b_o), 32'd0);
        chk("rst_mout", 32'(mout_o), 32'd0);
        chk("rst_ovf", 32'(ovf_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_state", 32'(state_o), 32'd0);

        do_op("basic", 4'b0011, 4'b1001);
        do_op("ovf", 4'b0101, 4'b0100);
        do_op("negzero", 4'b0011, 4'b1011);
        for (int i = 0; i < 6; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            do_op($sformatf("rnd%0d", i), ra, rb);
        end

        // Clear and next together while in GET_B: clear wins, nothing captured.
        sw = 4'b0110;
        press_next();
        press_next();
        chk("clr_pre_state", 32'(state_o), 32'd2);
        sw = 4'b1111;
        @(negedge clk);
        btn_next = 1'b1;
        btn_clr  = 1'b1;
        repeat (3) @(negedge clk);
        btn_next = 1'b0;
        btn_clr  = 1'b0;
        repeat (4) @(negedge clk);
        chk("clr_state", 32'(state_o), 32'd0);
        chk("clr_a", 32'(a_o), 32'd0);
        chk("clr_b", 32'(b_o), 32'd0);
        chk("clr_mout", 32'(mout_o), 32'd0);
        chk("clr_ovf", 32'(ovf_o), 32'd0);
        $display("clr+next in GET_B: state=%0d a=%b b=%b", state_o, a_o, b_o);

        // Long hold gives a single step.
        seq_code = 0;
        @(negedge clk) btn_next = 1'b1;
        repeat (200) @(negedge clk);
        btn_next = 1'b0;
        repeat (4) @(negedge clk);
        chk("hold_state", 32'(state_o), 32'd1);
        chk("hold_seq", 32'(seq_code), 32'd1);
        $display("hold 200: state=%0d", state_o);

        press_clr();
        chk("clr2_state", 32'(state_o), 32'd0);

        // Button held across reset release produces no step.
        @(negedge clk) btn_next = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("hold_rst_state", 32'(state_o), 32'd0);
        btn_next = 1'b0;
        repeat (4) @(negedge clk);
        chk("hold_rst_rel_state", 32'(state_o), 32'd0);
        $display("hold through reset: state=%0d", state_o);

        // Asynchronous reset mid-SHOW.
        do_op("pre_arst", 4'b0101, 4'b0100);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state_o), 32'd0);
        chk("arst_a", 32'(a_o), 32'd0);
        chk("arst_b", 32'(b_o), 32'd0);
        chk("arst_mout", 32'(mout_o), 32'd0);
        chk("arst_ovf", 32'(ovf_o), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        press_next();
        chk("arst_next_state", 32'(state_o), 32'd1);
        $display("async reset in SHOW then next: state=%0d", state_o);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sm_add_seq_ctrl.md
Name: sm_add_seq_ctrl

Overview:
Sequencing controller for the N-bit sign-magnitude adder on the board demo path. It steps the user through operand entry (A, then B) from the switches using a "next" button. It registers the operands driving the combinational adder, latches the result with overflow and negative-zero correction, and drives the value shown through the display mux. A "clear" button aborts to idle from any state.

Parameters:
N, 4, operand/result width in sign-magnitude (bit N-1 = sign, bits N-2:0 = magnitude)

Ports:
clk_amisha  in  1  system clock
reset_amisha  in  1  asynchronous, active-low reset
btn_next_amisha  in  1  step button, raw level (externally debounced, asynchronous to clk)
btn_clr_amisha  in  1  clear/abort button, raw level (externally debounced)
sw_amisha  in  N  operand value from switches, sign-magnitude
sum_amisha  in  N  result from external combinational sign-magnitude adder
a_amisha  out  N  registered operand A to adder
b_amisha  out  N  registered operand B to adder
mout_amisha  out  N  registered value for display
ovf_amisha  out  1  overflow flag for current result
done_amisha  out  1  one-cycle pulse when result latched
state_amisha  out  3  current state code

Behaviour:
- Reset (async, reset_amisha=0): state=IDLE; a, b, mout, result register = 0; ovf=0; done=0. Synchronizer and edge-history flops reset to 1, so a button held across reset release generates no pulse.
- Button conditioning, per button: 2-flop synchronizer plus a history flop. pulse = sync2 & ~hist. Exactly one pulse per press regardless of hold length.
- Latency: button first sampled high at edge k; pulse high in cycle k+2; state updates at edge k+3.
- State codes: IDLE=0, GET_A=1, GET_B=2, ADD=3, SHOW=4. Codes 5-7 are illegal and return to IDLE on the next edge.
- Transitions:
  - clr pulse, any state: go to IDLE; a, b, result, ovf cleared. clr wins over a simultaneous next.
  - IDLE: next -> GET_A.
  - GET_A: mout <= sw each cycle. next -> capture a <= sw, go GET_B.
  - GET_B: mout <= sw each cycle. next -> capture b <= sw, go ADD.
  - ADD: exactly one cycle, unconditional. sum_amisha is valid because a/b have been stable since the previous edge. At the end of ADD, latch the result and ovf and go SHOW. done=1 during the first SHOW cycle only.
  - SHOW: mout = result; ovf held. next -> GET_A with ovf cleared; a and b hold old values until recaptured.
- next pulses arriving in ADD are ignored, not queued.
- Overflow: ovf=1 iff a[N-1]==b[N-1] and a[N-2:0]+b[N-2:0] > 2^(N-1)-1. Computed internally at N bits of width. Result is still sum_amisha, flagged. Operands of differing sign never overflow.
- Negative zero: if the latched magnitude is 0, the sign bit is forced to 0. This applies to the result only; operands are passed through unmodified.
- ovf_amisha is 0 in every state except SHOW.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- N=4, reset, then next x3 with sw=0011 then sw=1001, adder model connected -> a=0011, b=1001, SHOW with mout=0010, ovf=0, done high exactly 1 cycle, state sequence 0,1,2,3,4.
- A=0101 (+5), B=0100 (+4) -> ovf=1 in SHOW, mout=adder output. Next press -> GET_A, ovf=0.
- A=0011 (+3), B=1011 (-3), adder outputs 1000 -> mout=0000 (negative zero cleared).
- In GET_B, assert clr and next in the same cycle -> IDLE, a=b=mout=0, no B capture.
- Hold btn_next high for 200 cycles from IDLE -> single transition to GET_A only. Hold button through reset deassertion -> no transition.
- Assert reset_amisha low mid-SHOW, asynchronously between edges -> outputs zero immediately, state=0. Next press after release -> GET_A.
